// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the core's load/store port with RV32I lane handling.
// Optional MISALIGN_TRAP_EN: flag misaligned/unsupported accesses on err and suppress them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] DAD,
  input  logic [31:0] DDT,
  output logic [31:0] ReadDDT,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           accept, enter_resp;

  logic [AW+1:0]  addr_p1;
  logic [31:0]    wdata_p1;
  logic           we_p1;
  logic [2:0]     f3_p1;

  logic [AW+1:0]  addr_sel;
  logic           we_sel;
  logic [2:0]     f3_sel;
  logic           bad_sel, bad_p1;
  logic [31:0]    load_value;
  logic [3:0]     be_p1;
  logic [31:0]    lanes_p1;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           unused_addr_hi;
  assign unused_addr_hi = ^DAD[31:AW+2];

  function automatic logic unsupported(input logic w, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b0;
      3'b100, 3'b101:         return w;
      default:                return 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic is_bad(input logic w, input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    return unsupported(w, f3) | misaligned(f3, a);
`else
    return unsupported(w, f3) | (misaligned(f3, a) & 1'b0);
`endif
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = word[8*a +: 8];
    h_s = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b100:  return {24'b0, b_s};
      3'b001:  return 32'(h_s);
      3'b101:  return {16'b0, h_s};
      3'b010:  return word;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // In IDLE the live request fields are used so LATENCY=1 can register load data at acceptance.
  always_comb begin
    addr_sel = addr_p1;
    we_sel   = we_p1;
    f3_sel   = f3_p1;
    if (state == IDLE) begin
      addr_sel = DAD[AW+1:0];
      we_sel   = we;
      f3_sel   = funct3;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- stage p1: request fields captured at acceptance ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= DAD[AW+1:0];
      wdata_p1 <= DDT;
      we_p1    <= we;
      f3_p1    <= funct3;
    end
  end

  assign bad_sel    = is_bad(we_sel, f3_sel, addr_sel[1:0]);
  assign load_value = bad_sel ? 32'b0
                              : load_extend(mem[addr_sel[AW+1:2]], f3_sel, addr_sel[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ReadDDT <= 32'b0;
    end else if (enter_resp && !we_sel) begin
      ReadDDT <= load_value;
    end
  end

  // ---- RESP stage: store commit ----
  assign bad_p1   = is_bad(we_p1, f3_p1, addr_p1[1:0]);
  assign be_p1    = store_be(f3_p1, addr_p1[1:0]);
  assign lanes_p1 = store_lanes(f3_p1, wdata_p1);

  always_ff @(posedge clk) begin
    if (state == RESP && we_p1 && !bad_p1 && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) mem[addr_p1[AW+1:2]][8*b +: 8] <= lanes_p1[8*b +: 8];
      end
    end
  end

  assign ready = (state == RESP);
  assign stall = req & ~ready;

`ifdef MISALIGN_TRAP_EN
  assign err = (state == RESP) & bad_p1;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 1, 15; 1024 words each)
// share request fields; each has its own req line.
module tb_data_mem_responder;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, req2;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] DAD, DDT;
  logic [31:0] rd0, rd1, rd2;
  logic        ready0, ready1, ready2;
  logic        stall0, stall1, stall2;
  logic        err0, err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_main (
    .clk(clk), .rst(rst), .req(req0), .we(we), .funct3(funct3), .DAD(DAD), .DDT(DDT),
    .ReadDDT(rd0), .ready(ready0), .stall(stall0), .err(err0));

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .funct3(funct3), .DAD(DAD), .DDT(DDT),
    .ReadDDT(rd1), .ready(ready1), .stall(stall1), .err(err1));

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .funct3(funct3), .DAD(DAD), .DDT(DDT),
    .ReadDDT(rd2), .ready(ready2), .stall(stall2), .err(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_ready(input int sel);
    case (sel)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  function automatic logic cur_stall(input int sel);
    case (sel)
      0:       return stall0;
      1:       return stall1;
      default: return stall2;
    endcase
  endfunction

  function automatic logic [31:0] cur_rd(input int sel);
    case (sel)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic cur_err(input int sel);
    case (sel)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req0 = v;
      1:       req1 = v;
      default: req2 = v;
    endcase
  endtask

  // One complete access; returns the load data, err and the cycle count to ready (-1 on timeout).
  task automatic access(input int sel, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input string tag,
                        output logic [31:0] rd, output logic e, output int lat);
    logic stall_bad;
    stall_bad = 1'b0;
    lat = -1;
    @(negedge clk);
    we = w; funct3 = f3; DAD = a; DDT = d;
    set_req(sel, 1'b1);
    #1;
    if (!cur_stall(sel)) stall_bad = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cur_ready(sel)) begin
        lat = k;
        break;
      end
      if (!cur_stall(sel)) stall_bad = 1'b1;
    end
    if (cur_stall(sel)) stall_bad = 1'b1;
    rd = cur_rd(sel);
    e  = cur_err(sel);
    set_req(sel, 1'b0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(cur_ready(sel)), 32'd0);
    chk({tag, "_stall"}, 32'(stall_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        seen;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    we = 1'b0; funct3 = 3'b010; DAD = '0; DDT = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_rd", rd0, 32'h0);
    chk("rst_stall", 32'(stall0), 32'd0);
    rst = 1'b0;

    // word store / load with LATENCY 2
    access(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, "sw1", rd, e, lat);
    chk("sw1_lat", 32'(lat), 32'd2);
    chk("sw1_err", 32'(e), 32'd0);
    access(0, 1'b0, 3'b010, 32'h100, 32'h0, "lw1", rd, e, lat);
    chk("lw1_lat", 32'(lat), 32'd2);
    chk("lw1_data", rd, 32'hDEADBEEF);

    // byte store and signed/unsigned byte loads
    access(0, 1'b1, 3'b000, 32'h103, 32'h123456A5, "sb", rd, e, lat);
    access(0, 1'b0, 3'b000, 32'h103, 32'h0, "lb", rd, e, lat);
    chk("lb_data", rd, 32'hFFFFFFA5);
    access(0, 1'b0, 3'b100, 32'h103, 32'h0, "lbu", rd, e, lat);
    chk("lbu_data", rd, 32'h000000A5);
    access(0, 1'b0, 3'b010, 32'h100, 32'h0, "lw2", rd, e, lat);
    chk("lw2_data", rd, 32'hA5ADBEEF);

    // half store and signed/unsigned half loads
    access(0, 1'b1, 3'b001, 32'h102, 32'h00008001, "sh", rd, e, lat);
    access(0, 1'b0, 3'b001, 32'h102, 32'h0, "lh", rd, e, lat);
    chk("lh_data", rd, 32'hFFFF8001);
    access(0, 1'b0, 3'b101, 32'h102, 32'h0, "lhu", rd, e, lat);
    chk("lhu_data", rd, 32'h00008001);
    access(0, 1'b0, 3'b010, 32'h100, 32'h0, "lw3", rd, e, lat);
    chk("lw3_data", rd, 32'h8001BEEF);

    // reset in the middle of a store discards it
    access(0, 1'b1, 3'b010, 32'h200, 32'h11111111, "sw4a", rd, e, lat);
    @(negedge clk);
    we = 1'b1; funct3 = 3'b010; DAD = 32'h200; DDT = 32'h22222222; req0 = 1'b1;
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(ready0), 32'd0);
    chk("midrst_rd", rd0, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready0) seen = 1'b1;
    end
    chk("midrst_nopulse", 32'(seen), 32'd0);

    // reset together with a request: request is dropped
    we = 1'b1; funct3 = 3'b010; DAD = 32'h200; DDT = 32'h33333333;
    rst = 1'b1; req0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready0) seen = 1'b1;
    end
    chk("rstreq_nopulse", 32'(seen), 32'd0);
    access(0, 1'b0, 3'b010, 32'h200, 32'h0, "lw4", rd, e, lat);
    chk("lw4_data", rd, 32'h11111111);

    // address aliasing across the three latencies
    access(0, 1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, "sw5", rd, e, lat);
    access(0, 1'b0, 3'b010, 32'h0004, 32'h0, "lw5", rd, e, lat);
    chk("lw5_alias", rd, 32'hCAFEF00D);
    access(1, 1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, "sw5a", rd, e, lat);
    chk("sw5a_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 3'b010, 32'h0004, 32'h0, "lw5a", rd, e, lat);
    chk("lw5a_lat", 32'(lat), 32'd1);
    chk("lw5a_alias", rd, 32'hCAFEF00D);
    access(2, 1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, "sw5b", rd, e, lat);
    chk("sw5b_lat", 32'(lat), 32'd15);
    access(2, 1'b0, 3'b010, 32'h0004, 32'h0, "lw5b", rd, e, lat);
    chk("lw5b_lat", 32'(lat), 32'd15);
    chk("lw5b_alias", rd, 32'hCAFEF00D);

    // unsupported funct3: no write, load returns 0
    access(0, 1'b0, 3'b011, 32'h100, 32'h0, "lbad", rd, e, lat);
    chk("lbad_data", rd, 32'h0);
    chk("lbad_err", 32'(e), 32'(TRAP));
    access(0, 1'b1, 3'b100, 32'h100, 32'h0, "sbad", rd, e, lat);
    chk("sbad_err", 32'(e), 32'(TRAP));
    access(0, 1'b0, 3'b010, 32'h100, 32'h0, "lw6", rd, e, lat);
    chk("lw6_data", rd, 32'h8001BEEF);

    // misaligned word store/load
    access(0, 1'b1, 3'b010, 32'h102, 32'h55667788, "swmis", rd, e, lat);
    chk("swmis_err", 32'(e), 32'(TRAP));
    access(0, 1'b0, 3'b010, 32'h102, 32'h0, "lwmis", rd, e, lat);
    chk("lwmis_err", 32'(e), 32'(TRAP));
    chk("lwmis_data", rd, TRAP ? 32'h0 : 32'h55667788);
    access(0, 1'b0, 3'b010, 32'h100, 32'h0, "lw7", rd, e, lat);
    chk("lw7_data", rd, TRAP ? 32'h8001BEEF : 32'h55667788);
    chk("lw7_err", 32'(e), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
